pc_bpred: RTL and testbench
===========================

PC_BPRED -- requirements
Module: pc_bpred

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high; clock clk.
REQ-003 stall  in  6  pipeline stall vector; only bit 0 (IF hold, 1=Stop) is used.
REQ-004 flush  in  1  exception redirect request.
REQ-005 new_pc  in  32  exception handler address, used when flush=1.
REQ-006 inst_i  in  32  instruction word at pc_o from instruction ROM, same cycle (combinational fetch).
REQ-007 upd_valid  in  1  resolved conditional branch this cycle.
REQ-008 upd_pc  in  32  PC of the resolved branch.
REQ-009 upd_taken  in  1  actual branch outcome.
REQ-010 upd_mispredict  in  1  prediction was wrong; redirect required.
REQ-011 upd_target  in  32  correct next PC on mispredict.
REQ-012 pc_o  out  32  fetch address; feeds if_pc of the IF/ID register.
REQ-013 ce_o  out  1  instruction-ROM chip enable.
REQ-014 pre_take_or_not_o  out  1  predicted taken for the instruction at pc_o.
REQ-015 pre_sel_o  out  1  predictor chosen: 0=bimodal, 1=gshare.

Function
REQ-016 Prediction tables: bimodal BHT, gshare PHT, chooser table; 16 entries of 2-bit saturating counters each.
REQ-017 Indices: bimodal and chooser = pc[5:2]; gshare = pc[5:2] XOR ghr[3:0].
REQ-018 ghr is a 4-bit non-speculative history; on upd_valid, ghr <= {ghr[2:0], upd_taken}.
REQ-019 Predecode: branch when inst_i[31:26] is 000100 (beq), 000101 (bne), 000111 (bgtz) or 000110 (blez); target = pc_o + 4 + (sign_ext(inst_i[15:0]) << 2), 32-bit wrap-around arithmetic.
REQ-020 pre_sel_o = chooser[idx][1] when predecoded branch, else 0.
REQ-021 pre_take_or_not_o = selected counter bit[1] when predecoded branch, else 0; both outputs combinational from pc_o and inst_i.
REQ-022 Next-PC priority: rst > flush (new_pc) > upd_valid & upd_mispredict (upd_target) > stall[0]=1 (hold) > predicted taken (target) > pc_o+4.
REQ-023 flush and mispredict redirects SHALL override stall[0]; younger wrong-path squash is the downstream stages' responsibility.
REQ-024 pc_o update latency 1 cycle; ce_o=0 forces pc_o to hold 0x00000000.
REQ-025 Counter update on upd_valid, irrespective of stall: taken increments, not-taken decrements, saturating at 3 and 0.
REQ-026 Bimodal counter at upd_pc[5:2] always updated; gshare counter at upd_pc[5:2] XOR ghr (pre-shift value) always updated.
REQ-027 Chooser updated only when bimodal and gshare predictions (bit[1] before update) differ: toward gshare (+1) if gshare was correct, else toward bimodal (-1), saturating.
REQ-028 Same-cycle lookup and update on one index: lookup returns pre-update value; new value visible next cycle.
REQ-029 pc_o increment and target arithmetic wrap 0xFFFFFFFC -> 0x00000000 with no flag.

Reset
REQ-030 On rst=1: pc_o=0x00000000, ce_o=0, ghr=0, all bimodal/gshare counters=01, all chooser counters=01.
REQ-031 ce_o=1 the first cycle after rst deasserts; first fetched pc_o=0x00000000.
REQ-032 rst asserted mid-operation overrides any simultaneous flush, redirect or table update.

Structure
REQ-033 Shared defines file holds: branch opcodes, counter init value 2'b01, table index width 4, GHR width 4, Stop/NoStop, RstEnable, ZeroWord.
REQ-034 One sub-module, sat_ctr_table (16x2-bit counter array, 1 read port, 1 read-modify-write update port), instantiated three times.

Verification
REQ-035 Reset released, inst_i=NOP, no stall -> ce_o=1, pc_o 0x0, 0x4, 0x8; both prediction outputs 0.
REQ-036 beq at 0x10 with imm=0x0003, counters reset -> pre_take_or_not_o=0, pre_sel_o=0, next pc_o=0x14; after two upd_valid taken at 0x10 -> predicted taken, next pc_o=0x20.
REQ-037 stall[0]=1 for 3 cycles at pc_o=0x40 -> pc_o holds 0x40; stall with mispredict upd_target=0x100 -> pc_o=0x100 next cycle.
REQ-038 flush=1, new_pc=0x00000180 concurrent with mispredict upd_target=0x200 -> pc_o=0x180.
REQ-039 Alternating taken/not-taken branch at 0x20, 20 updates -> chooser[8] saturates at 3, pre_sel_o=1, gshare predictions correct thereafter.
REQ-040 Counter at 3 updated taken -> stays 3; counter at 0 updated not-taken -> stays 0; pc_o=0xFFFFFFFC, no branch -> pc_o wraps to 0x0.

Source files
------------

// File: rtl/pc_bpred_pkg.sv
// pc_bpred_pkg: shared constants and helpers for the fetch-stage branch predictor
package pc_bpred_pkg;
  localparam int IDX_W = 4;
  localparam int GHR_W = 4;
  localparam int N_ENT = 1 << IDX_W;
  localparam logic [1:0] CTR_INIT = 2'b01;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_BLEZ = 6'b000110;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  function automatic logic is_branch(input logic [5:0] op);
    return op inside {OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ};
  endfunction

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic inc);
    return inc ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/pc_bpred_sat_ctr_table.sv
// sat_ctr_table: 16-entry 2-bit saturating counter array, one lookup port and one read-modify-write update port
module sat_ctr_table
  import pc_bpred_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_inc,
  output logic [1:0]       upd_old
);
  logic [1:0] ctr_q [N_ENT];
  logic [1:0] ctr_d [N_ENT];
  assign rd_ctr = ctr_q[rd_idx];
  assign upd_old = ctr_q[upd_idx];
  // bump the addressed counter toward the resolved direction, saturating
  always_comb begin
    ctr_d = ctr_q;
    if (upd_en) ctr_d[upd_idx] = sat_step(ctr_q[upd_idx], upd_inc);
  end
  // counters start weakly not-taken / weakly bimodal
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) ctr_q <= '{default: CTR_INIT};
    else ctr_q <= ctr_d;
  end
endmodule

// File: rtl/pc_bpred.sv
// pc_bpred: fetch PC register with tournament (bimodal/gshare) branch prediction
module pc_bpred
  import pc_bpred_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic [31:0] inst_i,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_mispredict,
  input  logic [31:0] upd_target,
  output logic [31:0] pc_o,
  output logic        ce_o,
  output logic        pre_take_or_not_o,
  output logic        pre_sel_o
);
  logic [31:0] pc_q, pc_d, seq_pc, br_tgt;
  logic ce_q, ce_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [IDX_W-1:0] bim_idx, gsh_idx, ubim_idx, ugsh_idx;
  logic [1:0] bim_ctr, gsh_ctr, ch_ctr, bim_old, gsh_old, ch_old_unused;
  logic br, ch_en, ch_inc;
  logic unused_bits;
  assign unused_bits = ^{stall[5:1], inst_i[25:16], upd_pc[31:6], upd_pc[1:0]};
  assign pc_o = pc_q;
  assign ce_o = ce_q;
  assign bim_idx = pc_q[5:2];
  assign gsh_idx = pc_q[5:2] ^ ghr_q;
  assign ubim_idx = upd_pc[5:2];
  assign ugsh_idx = upd_pc[5:2] ^ ghr_q;
  assign ch_en = upd_valid & (bim_old[1] ^ gsh_old[1]);
  assign ch_inc = gsh_old[1] == upd_taken;

  sat_ctr_table u_bim (
    .clk(clk), .rst(rst), .rd_idx(bim_idx), .rd_ctr(bim_ctr),
    .upd_en(upd_valid), .upd_idx(ubim_idx), .upd_inc(upd_taken), .upd_old(bim_old)
  );
  sat_ctr_table u_gsh (
    .clk(clk), .rst(rst), .rd_idx(gsh_idx), .rd_ctr(gsh_ctr),
    .upd_en(upd_valid), .upd_idx(ugsh_idx), .upd_inc(upd_taken), .upd_old(gsh_old)
  );
  sat_ctr_table u_ch (
    .clk(clk), .rst(rst), .rd_idx(bim_idx), .rd_ctr(ch_ctr),
    .upd_en(ch_en), .upd_idx(ubim_idx), .upd_inc(ch_inc), .upd_old(ch_old_unused)
  );

  // predecode the fetched word and pick a prediction; non-branches never predict taken
  always_comb begin
    br = is_branch(inst_i[31:26]);
    pre_sel_o = br & ch_ctr[1];
    pre_take_or_not_o = br & (ch_ctr[1] ? gsh_ctr[1] : bim_ctr[1]);
  end

  // next fetch address: redirects beat stall, stall beats prediction
  always_comb begin
    seq_pc = pc_q + 32'd4;
    br_tgt = seq_pc + {{14{inst_i[15]}}, inst_i[15:0], 2'b00};
    ce_d = 1'b1;
    ghr_d = upd_valid ? {ghr_q[GHR_W-2:0], upd_taken} : ghr_q;
    pc_d = !ce_q ? ZERO_WORD
         : flush ? new_pc
         : (upd_valid & upd_mispredict) ? upd_target
         : (stall[0] == STOP) ? pc_q
         : pre_take_or_not_o ? br_tgt
         : seq_pc;
  end

  // fetch state; reset wins over every redirect and history update
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pc_q <= ZERO_WORD;
      ce_q <= 1'b0;
      ghr_q <= '0;
    end else begin
      pc_q <= pc_d;
      ce_q <= ce_d;
      ghr_q <= ghr_d;
    end
  end
endmodule

// File: tb/tb_pc_bpred.sv
// tb_pc_bpred: directed self-checking bench for pc_bpred
module tb_pc_bpred;
  logic clk = 0, rst = 1, flush = 0;
  logic [5:0] stall = '0;
  logic [31:0] new_pc = '0, inst_i = '0, upd_pc = '0, upd_target = '0;
  logic upd_valid = 0, upd_taken = 0, upd_mispredict = 0;
  logic [31:0] pc_o;
  logic ce_o, pre_take_or_not_o, pre_sel_o;
  int total = 0, passed = 0, fails = 0;
  localparam logic [31:0] BEQ3 = 32'h1000_0003;
  localparam logic [31:0] BLEZ3 = 32'h1800_0003;
  localparam logic [31:0] BGTZ_M2 = 32'h1C00_FFFE;
  localparam logic [31:0] ADDI3 = 32'h2000_0003;

  always #5 clk = ~clk;

  pc_bpred dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc), .inst_i(inst_i),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .upd_target(upd_target),
    .pc_o(pc_o), .ce_o(ce_o), .pre_take_or_not_o(pre_take_or_not_o), .pre_sel_o(pre_sel_o)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic t);
    upd_valid = 1; upd_pc = pc; upd_taken = t;
    tick();
    upd_valid = 0;
  endtask

  task automatic go(input logic [31:0] a);
    flush = 1; new_pc = a;
    tick();
    flush = 0;
  endtask

  task automatic do_rst();
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  initial begin
    tick(); tick();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_ce", ce_o, 1'b0);
    rst = 0;
    tick();
    chk("first_ce", ce_o, 1'b1);
    chk("first_pc", pc_o, 32'h0);
    chk("nop_take", pre_take_or_not_o, 1'b0);
    chk("nop_sel", pre_sel_o, 1'b0);
    tick(); chk("seq_pc4", pc_o, 32'h4);
    tick(); chk("seq_pc8", pc_o, 32'h8);
    // cold beq at 0x10 falls through
    go(32'h10); chk("flush_pc10", pc_o, 32'h10);
    inst_i = BEQ3; #1;
    chk("cold_take", pre_take_or_not_o, 1'b0);
    chk("cold_sel", pre_sel_o, 1'b0);
    tick(); chk("cold_next", pc_o, 32'h14);
    inst_i = 0;
    // two taken updates: bimodal strong taken, chooser drops to bimodal
    upd(32'h10, 1); upd(32'h10, 1);
    go(32'h10); inst_i = BEQ3; #1;
    chk("warm_take", pre_take_or_not_o, 1'b1);
    chk("warm_sel", pre_sel_o, 1'b0);
    tick(); chk("warm_target", pc_o, 32'h20);
    go(32'h10); inst_i = ADDI3; #1;
    chk("nonbr_take", pre_take_or_not_o, 1'b0);
    tick(); chk("nonbr_next", pc_o, 32'h14);
    inst_i = 0;
    // stall hold, then mispredict overriding stall
    go(32'h40); stall = 6'b000001;
    repeat (3) begin tick(); chk("stall_hold", pc_o, 32'h40); end
    upd_valid = 1; upd_mispredict = 1; upd_target = 32'h100; upd_pc = 32'h3C; upd_taken = 1;
    tick(); chk("stall_mispred", pc_o, 32'h100);
    stall = 0;
    // flush beats mispredict
    flush = 1; new_pc = 32'h180; upd_target = 32'h200;
    tick(); chk("flush_over_mis", pc_o, 32'h180);
    // reset beats everything, tables return to init
    rst = 1; new_pc = 32'h300; upd_pc = 32'h10;
    tick();
    chk("midrst_pc", pc_o, 32'h0);
    chk("midrst_ce", ce_o, 1'b0);
    rst = 0; flush = 0; upd_valid = 0; upd_mispredict = 0;
    tick();
    chk("midrst_ce1", ce_o, 1'b1);
    chk("midrst_pc0", pc_o, 32'h0);
    go(32'h10); inst_i = BEQ3; #1;
    chk("midrst_tbl", pre_take_or_not_o, 1'b0);
    inst_i = 0;
    // alternating branch at 0x20: chooser moves to gshare
    for (int i = 0; i < 20; i++) upd(32'h20, (i % 2) == 0);
    go(32'h20); inst_i = BLEZ3; #1;
    chk("alt_sel", pre_sel_o, 1'b1);
    chk("alt_take", pre_take_or_not_o, 1'b1);
    tick(); chk("alt_target", pc_o, 32'h30);
    inst_i = 0;
    upd(32'h20, 1);
    go(32'h20); inst_i = BLEZ3; #1;
    chk("alt_sel2", pre_sel_o, 1'b1);
    chk("alt_nt", pre_take_or_not_o, 1'b0);
    tick(); chk("alt_seq", pc_o, 32'h24);
    inst_i = 0;
    // saturation at zero
    do_rst();
    repeat (3) upd(32'h4, 0);
    upd(32'h4, 1);
    go(32'h4); inst_i = BEQ3; #1;
    chk("sat0_take", pre_take_or_not_o, 1'b0);
    chk("sat0_sel", pre_sel_o, 1'b0);
    tick(); chk("sat0_next", pc_o, 32'h8);
    inst_i = 0;
    // saturation at three, then backward target
    do_rst();
    repeat (4) upd(32'h10, 1);
    upd(32'h10, 0);
    go(32'h10); inst_i = BGTZ_M2; #1;
    chk("sat3_take", pre_take_or_not_o, 1'b1);
    chk("sat3_sel", pre_sel_o, 1'b0);
    tick(); chk("back_target", pc_o, 32'hC);
    inst_i = 0;
    // wrap-around
    go(32'hFFFF_FFFC); chk("wrap_pre", pc_o, 32'hFFFF_FFFC);
    tick(); chk("wrap_zero", pc_o, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
